jtag_req_handshake: RTL and testbench

//  SoC-side (clk_i) end of the JTAG->SoC four-phase request channel. Consumes the

---
 rtl/jtag_req_handshake_pkg.sv | 11 +
 rtl/jtag_req_handshake.sv | 107 ++++++++++
 tb/tb_jtag_req_handshake.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jtag_req_handshake_pkg.sv
// Shared types for the JTAG->SoC request handshake.
// The FSM state encoding is shared so parents and checkers can decode busy phases.
package jtag_pulp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } jtag_hs_state_e;

endpackage

// File: rtl/jtag_req_handshake.sv
// SoC-side end of the JTAG four-phase request channel: captures the JTAG payload,
// runs one valid/ready transaction, and returns a level ack with response and error flag.
module jtag_req_handshake
    import jtag_pulp_pkg::*;
#(
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_sync_i,
    input  logic [DW-1:0] wdata_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] wdata_o,
    input  logic [DW-1:0] rdata_i,
    output logic          ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          err_o,
    output logic          busy_o
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam bit          WD_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST =
        WD_EN ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

    jtag_hs_state_e state_r, state_nxt_s;
    logic [DW-1:0]  wdata_r, wdata_nxt_s;
    logic [DW-1:0]  rdata_r, rdata_nxt_s;
    logic           err_r,   err_nxt_s;
    logic [CW-1:0]  cnt_r,   cnt_nxt_s;
    logic           timeout_hit_s;

    assign timeout_hit_s = WD_EN && (cnt_r == CNT_LAST);

    // Next-state and capture logic; ready_i is checked before the watchdog so a tie accepts.
    always_comb begin
        state_nxt_s = state_r;
        wdata_nxt_s = wdata_r;
        rdata_nxt_s = rdata_r;
        err_nxt_s   = err_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_sync_i) begin
                    state_nxt_s = REQ;
                    wdata_nxt_s = wdata_i;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (ready_i) begin
                    state_nxt_s = ACK;
                    rdata_nxt_s = rdata_i;
                    err_nxt_s   = 1'b0;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ACK;
                    rdata_nxt_s = {DW{1'b0}};
                    err_nxt_s   = 1'b1;
                end else if (WD_EN) begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s   = {CW{1'b0}};
                end
            end
            ACK: begin
                if (!req_sync_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops valid/ack asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            wdata_r <= {DW{1'b0}};
            rdata_r <= {DW{1'b0}};
            err_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wdata_r <= wdata_nxt_s;
            rdata_r <= rdata_nxt_s;
            err_r   <= err_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign valid_o = (state_r == REQ);
    assign ack_o   = (state_r == ACK);
    assign busy_o  = (state_r != IDLE);
    assign wdata_o = wdata_r;
    assign rdata_o = rdata_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_jtag_req_handshake.sv
// Bench for jtag_req_handshake: vector table on a TIMEOUT_CYCLES=8 instance,
// reset abort, and back-to-back traffic on a watchdog-disabled instance.
module tb_jtag_req_handshake;

    typedef struct {
        logic [31:0] wd;
        logic [31:0] rd;
        int          ready_at;
        int          drop_at;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req    [2];
    logic        ready  [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        valid_w [2];
    logic        ack_w   [2];
    logic        err_w   [2];
    logic        busy_w  [2];
    logic [31:0] wdo_w   [2];
    logic [31:0] rdo_w   [2];

    int  total = 0;
    int  bad   = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    jtag_req_handshake #(.DW(32), .TIMEOUT_CYCLES(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_sync_i(req[0]), .wdata_i(wdata[0]),
        .valid_o(valid_w[0]), .ready_i(ready[0]), .wdata_o(wdo_w[0]),
        .rdata_i(rdata[0]), .ack_o(ack_w[0]), .rdata_o(rdo_w[0]),
        .err_o(err_w[0]), .busy_o(busy_w[0])
    );

    jtag_req_handshake #(.DW(32), .TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_sync_i(req[1]), .wdata_i(wdata[1]),
        .valid_o(valid_w[1]), .ready_i(ready[1]), .wdata_o(wdo_w[1]),
        .rdata_i(rdata[1]), .ack_o(ack_w[1]), .rdata_o(rdo_w[1]),
        .err_o(err_w[1]), .busy_o(busy_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full four-phase transaction on instance k, checked against the scoreboard.
    task automatic run_txn(input int k, input logic [31:0] wd, input logic [31:0] rd,
                           input int ready_at, input int drop_at, input int exp_cyc,
                           input logic exp_err, input logic [31:0] exp_rd);
        sb_t e;
        int  vc;
        sb_q.push_back('{wd: wd, rd: exp_rd, err: exp_err});
        req[k]   = 1'b1;
        wdata[k] = wd;
        rdata[k] = rd;
        ready[k] = 1'b0;
        tick();
        chk("valid_rise", {31'd0, valid_w[k]}, 32'd1);
        chk("wdata_cap", wdo_w[k], wd);
        wdata[k] = ~wd;
        vc = 0;
        while (valid_w[k] === 1'b1 && vc < 200) begin
            vc++;
            if (vc == drop_at) req[k] = 1'b0;
            ready[k] = (vc == ready_at);
            tick();
        end
        ready[k] = 1'b0;
        chk("valid_cycles", vc, exp_cyc);
        chk("ack_rise", {31'd0, ack_w[k]}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("wdata_hold", wdo_w[k], e.wd);
            chk("rdata", rdo_w[k], e.rd);
            chk("err", {31'd0, err_w[k]}, {31'd0, e.err});
        end
        if (req[k]) begin
            tick();
            chk("ack_hold", {31'd0, ack_w[k]}, 32'd1);
            req[k] = 1'b0;
        end
        tick();
        chk("ack_fall", {31'd0, ack_w[k]}, 32'd0);
        chk("busy_fall", {31'd0, busy_w[k]}, 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'h12345678, 3, 0, 3, 1'b0, 32'h12345678};
        vecs[1] = '{32'hA5A5A5A5, 32'hFFFFFFFF, 0, 0, 8, 1'b1, 32'h00000000};
        vecs[2] = '{32'h0BADF00D, 32'h87654321, 8, 0, 8, 1'b0, 32'h87654321};
        vecs[3] = '{32'h11112222, 32'h33334444, 9, 0, 8, 1'b1, 32'h00000000};
        vecs[4] = '{32'hCAFEF00D, 32'h5555AAAA, 5, 2, 5, 1'b0, 32'h5555AAAA};

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; ready[i] = 1'b0; wdata[i] = 32'd0; rdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_w[0]}, 32'd0);
        chk("rst_ack", {31'd0, ack_w[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("rst_err", {31'd0, err_w[0]}, 32'd0);
        chk("rst_wdata", wdo_w[0], 32'd0);
        chk("rst_rdata", rdo_w[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(0, vecs[i].wd, vecs[i].rd, vecs[i].ready_at, vecs[i].drop_at,
                    vecs[i].exp_cyc, vecs[i].exp_err, vecs[i].exp_rd);
        end

        // Reset in the middle of REQ: outputs must drop without a clock edge.
        req[0] = 1'b1;
        wdata[0] = 32'h77778888;
        tick();
        chk("pre_rst_valid", {31'd0, valid_w[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_w[0]}, 32'd0);
        chk("arst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("arst_ack", {31'd0, ack_w[0]}, 32'd0);
        chk("arst_rdata", rdo_w[0], 32'd0);
        chk("arst_err", {31'd0, err_w[0]}, 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back with the watchdog disabled; long delays must not time out.
        for (int t = 0; t < 4; t++) begin
            logic [31:0] wd;
            logic [31:0] rd;
            int          dly;
            wd  = $urandom();
            rd  = $urandom();
            dly = (t == 0) ? 20 : int'($urandom_range(1, 15));
            run_txn(1, wd, rd, dly, 0, dly, 1'b0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
